// File: rtl/id_ex_register_pkg.sv
// Shared ID/EX and EX/MEM definitions: operand-select, ALU and memory-size codes,
// plus the control bundle layout so both pipeline registers agree on field order.
package id_ex_register_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    SI_RS2   = 3'd0,
    SI_IMM_I = 3'd1,
    SI_IMM_S = 3'd2,
    SI_IMM_U = 3'd3,
    SI_PC    = 3'd4,
    SI_FOUR  = 3'd5
  } si_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    si_e       si;
    alu_op_e   alu_op;
    logic [4:0] rd;
    logic      rf_we;
    logic      mem_rd;
    logic      mem_wr;
    mem_size_e mem_size;
    logic      mem_se;
    logic      br;
    logic      jal;
    logic      jalr;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  // All-zero control is the canonical NOP: no write, no memory access, no transfer.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: stall/flush, decoded ID fields in, registered EX fields out.
interface id_ex_register_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_pa;
  logic [XLEN-1:0]  id_pb;
  logic [11:0]      id_imm12_i;
  logic [11:0]      id_imm12_s;
  logic [19:0]      id_imm20;
  logic [2:0]       id_si;
  logic [3:0]       id_alu_op;
  logic [4:0]       id_rd;
  logic             id_rf_we;
  logic             id_mem_rd;
  logic             id_mem_wr;
  logic [1:0]       id_mem_size;
  logic             id_mem_se;
  logic             id_br;
  logic             id_jal;
  logic             id_jalr;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_pa;
  logic [XLEN-1:0]  ex_pb;
  logic [XLEN-1:0]  ex_imm12_i;
  logic [XLEN-1:0]  ex_imm12_s;
  logic [19:0]      ex_imm20;
  logic [2:0]       ex_si;
  logic [3:0]       ex_alu_op;
  logic [4:0]       ex_rd;
  logic             ex_rf_we;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic [1:0]       ex_mem_size;
  logic             ex_mem_se;
  logic             ex_br;
  logic             ex_jal;
  logic             ex_jalr;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_pc, id_pa, id_pb, id_imm12_i, id_imm12_s, id_imm20,
           id_si, id_alu_op, id_rd, id_rf_we, id_mem_rd, id_mem_wr, id_mem_size, id_mem_se,
           id_br, id_jal, id_jalr,
    input  ex_valid, ex_pc, ex_pa, ex_pb, ex_imm12_i, ex_imm12_s, ex_imm20, ex_si, ex_alu_op,
           ex_rd, ex_rf_we, ex_mem_rd, ex_mem_wr, ex_mem_size, ex_mem_se, ex_br, ex_jal,
           ex_jalr, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_pa, id_pb, id_imm12_i, id_imm12_s, id_imm20,
           id_si, id_alu_op, id_rd, id_rf_we, id_mem_rd, id_mem_wr, id_mem_size, id_mem_se,
           id_br, id_jal, id_jalr,
    output ex_valid, ex_pc, ex_pa, ex_pb, ex_imm12_i, ex_imm12_s, ex_imm20, ex_si, ex_alu_op,
           ex_rd, ex_rf_we, ex_mem_rd, ex_mem_wr, ex_mem_size, ex_mem_se, ex_br, ex_jal,
           ex_jalr, bubble_cnt
  );

endinterface

// File: rtl/id_ex_register_pipe_field.sv
// Generic W-bit pipeline field: clear beats hold beats load; async reset to zero.
module id_ex_register_pipe_field #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle capture of decoded control and operands with
// stall (hold), flush (bubble) and a saturating bubble counter for debug.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  id_ex_register_if.slave bus
);

  localparam int DATA_W = 5 * XLEN + 20;

  ctrl_t             w_ctrl_d;
  ctrl_t             w_ctrl_q;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [DATA_W-1:0] w_data_d;
  logic [DATA_W-1:0] w_data_q;
  logic              w_valid_q;
  logic              w_bubble;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // A bubble is written on flush, or on an unstalled load of an invalid ID slot.
  assign w_bubble = bus.flush | (~bus.stall & ~bus.id_valid);

  always_comb begin
    w_ctrl_d          = CTRL_NOP;
    w_ctrl_d.si       = si_e'(bus.id_si);
    w_ctrl_d.alu_op   = alu_op_e'(bus.id_alu_op);
    w_ctrl_d.rd       = bus.id_rd;
    w_ctrl_d.rf_we    = bus.id_rf_we;
    w_ctrl_d.mem_rd   = bus.id_mem_rd;
    w_ctrl_d.mem_wr   = bus.id_mem_wr;
    w_ctrl_d.mem_size = mem_size_e'(bus.id_mem_size);
    w_ctrl_d.mem_se   = bus.id_mem_se;
    w_ctrl_d.br       = bus.id_br;
    w_ctrl_d.jal      = bus.id_jal;
    w_ctrl_d.jalr     = bus.id_jalr;
  end

  assign w_imm_i  = {{(XLEN-12){bus.id_imm12_i[11]}}, bus.id_imm12_i};
  assign w_imm_s  = {{(XLEN-12){bus.id_imm12_s[11]}}, bus.id_imm12_s};
  assign w_data_d = {bus.id_pc, bus.id_pa, bus.id_pb, w_imm_i, w_imm_s, bus.id_imm20};

  // Control clears on any bubble; data only clears on flush so bubbles keep operands.
  id_ex_register_pipe_field #(.W(CTRL_W)) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (bus.stall),
    .i_clear (w_bubble),
    .i_d     (w_ctrl_d),
    .o_q     (w_ctrl_q)
  );

  id_ex_register_pipe_field #(.W(DATA_W)) u_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (bus.stall),
    .i_clear (bus.flush),
    .i_d     (w_data_d),
    .o_q     (w_data_q)
  );

  id_ex_register_pipe_field #(.W(1)) u_valid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (bus.stall),
    .i_clear (bus.flush),
    .i_d     (bus.id_valid),
    .o_q     (w_valid_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign {bus.ex_pc, bus.ex_pa, bus.ex_pb, bus.ex_imm12_i, bus.ex_imm12_s, bus.ex_imm20} = w_data_q;

  assign bus.ex_valid    = w_valid_q;
  assign bus.ex_si       = w_ctrl_q.si;
  assign bus.ex_alu_op   = w_ctrl_q.alu_op;
  assign bus.ex_rd       = w_ctrl_q.rd;
  assign bus.ex_rf_we    = w_ctrl_q.rf_we;
  assign bus.ex_mem_rd   = w_ctrl_q.mem_rd;
  assign bus.ex_mem_wr   = w_ctrl_q.mem_wr;
  assign bus.ex_mem_size = w_ctrl_q.mem_size;
  assign bus.ex_mem_se   = w_ctrl_q.mem_se;
  assign bus.ex_br       = w_ctrl_q.br;
  assign bus.ex_jal      = w_ctrl_q.jal;
  assign bus.ex_jalr     = w_ctrl_q.jalr;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register with hand-computed expectations (CNT_W=4).
module tb_id_ex_register;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  id_ex_register_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_pc       = '0;
    bus.id_pa       = '0;
    bus.id_pb       = '0;
    bus.id_imm12_i  = '0;
    bus.id_imm12_s  = '0;
    bus.id_imm20    = '0;
    bus.id_si       = '0;
    bus.id_alu_op   = '0;
    bus.id_rd       = '0;
    bus.id_rf_we    = 1'b0;
    bus.id_mem_rd   = 1'b0;
    bus.id_mem_wr   = 1'b0;
    bus.id_mem_size = '0;
    bus.id_mem_se   = 1'b0;
    bus.id_br       = 1'b0;
    bus.id_jal      = 1'b0;
    bus.id_jalr     = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [3];
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_cnt", bus.bubble_cnt, 0);
    chk("rst_pc", bus.ex_pc, 0);

    // Reset in the middle of operation
    rst_n        = 1'b1;
    bus.id_valid = 1'b1;
    bus.id_pc    = 32'h40;
    bus.id_rf_we = 1'b1;
    tick();
    chk("pre_rst_pc", bus.ex_pc, 32'h40);
    chk("pre_rst_we", bus.ex_rf_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.ex_pc, 0);
    chk("async_rst_we", bus.ex_rf_we, 0);
    chk("async_rst_valid", bus.ex_valid, 0);
    chk("async_rst_cnt", bus.bubble_cnt, 0);
    rst_n = 1'b1;

    // Normal load with sign extension
    bus.id_imm12_i  = 12'hC0C;
    bus.id_imm12_s  = 12'h70F;
    bus.id_imm20    = 20'hEC44F;
    bus.id_pb       = 32'h0431_FFEA;
    bus.id_si       = 3'b010;
    bus.id_alu_op   = 4'hA;
    bus.id_rd       = 5'd17;
    bus.id_mem_size = 2'd2;
    bus.id_jalr     = 1'b1;
    tick();
    chk("ld_imm_i", bus.ex_imm12_i, 32'hFFFF_FC0C);
    chk("ld_imm_s", bus.ex_imm12_s, 32'h0000_070F);
    chk("ld_imm20", bus.ex_imm20, 20'hEC44F);
    chk("ld_pb", bus.ex_pb, 32'h0431_FFEA);
    chk("ld_si", bus.ex_si, 3'b010);
    chk("ld_valid", bus.ex_valid, 1);
    chk("ld_alu_op", bus.ex_alu_op, 4'hA);
    chk("ld_rd", bus.ex_rd, 5'd17);
    chk("ld_mem_size", bus.ex_mem_size, 2'd2);
    chk("ld_jalr", bus.ex_jalr, 1);
    chk("ld_cnt", bus.bubble_cnt, 0);

    // Stall holds everything
    clear_inputs();
    bus.id_valid = 1'b1;
    bus.id_pc    = 32'h100;
    tick();
    chk("st_pc0", bus.ex_pc, 32'h100);
    bus.stall    = 1'b1;
    bus.id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc = pcs[i];
      tick();
      chk("st_hold_pc", bus.ex_pc, 32'h100);
      chk("st_hold_valid", bus.ex_valid, 1);
      chk("st_hold_cnt", bus.bubble_cnt, 0);
    end
    bus.stall    = 1'b0;
    bus.id_valid = 1'b1;
    tick();
    chk("st_release_pc", bus.ex_pc, 32'h10C);

    // Flush wins over stall
    bus.id_mem_wr = 1'b1;
    bus.id_imm12_i = 12'hFFF;
    tick();
    chk("fl_pre_mem_wr", bus.ex_mem_wr, 1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    chk("fl_mem_wr", bus.ex_mem_wr, 0);
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_pc", bus.ex_pc, 0);
    chk("fl_imm_i", bus.ex_imm12_i, 0);
    chk("fl_cnt", bus.bubble_cnt, 1);

    // Bubble via id_valid=0: control cleared, data kept
    clear_inputs();
    bus.id_rf_we = 1'b1;
    bus.id_pa    = 32'h1234;
    tick();
    chk("bub_rf_we", bus.ex_rf_we, 0);
    chk("bub_valid", bus.ex_valid, 0);
    chk("bub_pa", bus.ex_pa, 32'h1234);
    chk("bub_cnt", bus.bubble_cnt, 2);
    bus.stall = 1'b1;
    tick();
    chk("bub_stall_cnt", bus.bubble_cnt, 2);
    bus.stall    = 1'b0;
    bus.id_valid = 1'b1;
    tick();
    chk("bub_to_valid", bus.ex_valid, 1);
    chk("bub_to_valid_we", bus.ex_rf_we, 1);
    chk("bub_to_valid_cnt", bus.bubble_cnt, 2);

    // Counter saturation
    #2 rst_n = 1'b0;
    clear_inputs();
    bus.flush = 1'b1;
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat_cnt", bus.bubble_cnt, (i > 15) ? 15 : i);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
